// File: rtl/msg_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : msg_block_buffer
// Description : Assembles the serial message byte stream into a 64-byte
//               little-endian BLAKE2s message block, computes the BLAKE2 byte
//               counter t for each block, and presents {m, t, first, last} to
//               the compression core through a single-block hold register
//               with a valid/ack handshake.
// Ports       : clk, nreset          - clock, synchronous active-low reset
//               data_v_i/data_i/data_idx_i - byte strobe, byte, byte position
//               block_first_i/block_last_i - block position in the message
//               kk_i, ll_i           - key length, message length (bytes)
//               blk_ack_i            - core consumed the held block
//               ready_o              - buffer can accept a new block
//               blk_v_o/blk_m_o/blk_t_o/blk_first_o/blk_last_o - held block
//               ovf_o                - sticky: block lost because hold full
// Revision    : 1.0 - initial release
// ============================================================================
module msg_block_buffer #(
  parameter int BB_LOG2 = 6,
  parameter int T_W     = 64
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          data_v_i,
  input  logic [7:0]                    data_i,
  input  logic [BB_LOG2-1:0]            data_idx_i,
  input  logic                          block_first_i,
  input  logic                          block_last_i,
  input  logic [5:0]                    kk_i,
  input  logic [T_W-1:0]                ll_i,
  input  logic                          blk_ack_i,
  output logic                          ready_o,
  output logic                          blk_v_o,
  output logic [8*(2**BB_LOG2)-1:0]     blk_m_o,
  output logic [T_W-1:0]                blk_t_o,
  output logic                          blk_first_o,
  output logic                          blk_last_o,
  output logic                          ovf_o
);

  localparam int             c_NB        = 2**BB_LOG2;
  localparam int             c_MW        = 8*c_NB;
  localparam logic [T_W-1:0] c_BLK_BYTES = T_W'(c_NB);

  logic [c_MW-1:0] r_fill;
  logic [c_MW-1:0] r_blk_m;
  logic [T_W-1:0]  r_blk_t;
  logic [T_W-1:0]  r_t;
  logic            r_hold_v;
  logic            r_blk_first;
  logic            r_blk_last;
  logic            r_ovf;

  logic            w_complete;
  logic            w_transfer;
  logic [c_MW-1:0] w_m_merged;
  logic [T_W-1:0]  w_t_base;
  logic [T_W-1:0]  w_t_run;
  logic [T_W-1:0]  w_t_last;
  logic [T_W-1:0]  w_t_blk;

  // The final byte position closes the block; its byte is still being written
  // into r_fill this cycle, so the transferred block splices it in directly.
  assign w_complete = data_v_i && (data_idx_i == {BB_LOG2{1'b1}});
  assign w_m_merged = {data_i, r_fill[c_MW-9:0]};

  // An ack arriving with completion frees the hold in the same cycle.
  assign w_transfer = w_complete && (!r_hold_v || blk_ack_i);

  // A keyed message carries the padded key block in front of the data, so the
  // final counter includes one extra block of bytes.
  assign w_t_base = block_first_i ? '0 : r_t;
  assign w_t_run  = w_t_base + c_BLK_BYTES;
  assign w_t_last = ll_i + ((kk_i != 6'd0) ? c_BLK_BYTES : '0);
  assign w_t_blk  = block_last_i ? w_t_last : w_t_run;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_fill      <= '0;
      r_blk_m     <= '0;
      r_blk_t     <= '0;
      r_t         <= '0;
      r_hold_v    <= 1'b0;
      r_blk_first <= 1'b0;
      r_blk_last  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      // Bytes land regardless of ready_o; position is purely data_idx_i.
      for (int k = 0; k < c_NB; k++) begin
        if (data_v_i && (data_idx_i == BB_LOG2'(k))) begin
          r_fill[8*k +: 8] <= data_i;
        end
      end

      if (w_transfer) begin
        r_blk_m     <= w_m_merged;
        r_blk_t     <= w_t_blk;
        r_blk_first <= block_first_i;
        r_blk_last  <= block_last_i;
        r_hold_v    <= 1'b1;
        r_t         <= block_last_i ? '0 : w_t_run;
      end else if (blk_ack_i && r_hold_v) begin
        r_hold_v    <= 1'b0;
      end

      // Dropped block: counter is left untouched so the stream can be resent.
      if (w_complete && r_hold_v && !blk_ack_i) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ready_o     = ~r_hold_v;
  assign blk_v_o     = r_hold_v;
  assign blk_m_o     = r_blk_m;
  assign blk_t_o     = r_blk_t;
  assign blk_first_o = r_blk_first;
  assign blk_last_o  = r_blk_last;
  assign ovf_o       = r_ovf;

endmodule
`default_nettype wire
